// File: rtl/reg_file_pkg.sv
// Shared constants for the register file: default data and address widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reg_file_pkg;

  // Top-level defaults; instances may override through parameters.
  localparam int RF_WIDTH  = 16;
  localparam int RF_ADDR_W = 3;

  // Number of registers addressed by an ADDR_W-bit address.
  function automatic int rf_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/reg_file_param_if.sv
// Bundle of the decode/writeback-facing register file signals.
// Latency: n/a (wiring only).
// Backpressure: none; issue logic stalls on busy_a/busy_b.
interface reg_file_param_if
  import reg_file_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH,
  parameter int ADDR_W = RF_ADDR_W
);
  // Writeback port
  logic              wr;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  d_in;
  // Decode read ports
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [WIDTH-1:0]  d_out_a;
  logic [WIDTH-1:0]  d_out_b;
  // Producer scoreboard
  logic              rsv;
  logic [ADDR_W-1:0] rsv_addr;
  logic              busy_a;
  logic              busy_b;
  logic              rsv_err;

  // Pipeline side: drives writes, reads and reserves
  modport master (
    output wr, wr_addr, d_in, rd_addr_a, rd_addr_b, rsv, rsv_addr,
    input  d_out_a, d_out_b, busy_a, busy_b, rsv_err
  );

  // Register file side
  modport slave (
    input  wr, wr_addr, d_in, rd_addr_a, rd_addr_b, rsv, rsv_addr,
    output d_out_a, d_out_b, busy_a, busy_b, rsv_err
  );
endinterface

// File: rtl/reg_file_param_dfrl_n.sv
// WIDTH-bit load-enabled storage register with synchronous reset.
// Latency: 1 cycle from i_ld to o_q.
// Backpressure: none; loads whenever i_ld is high.
module dfrl_n #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ld,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;

  // Hold value unless loaded; reset clears to zero
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_ld) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/reg_file_param.sv
// Multi-port register file with per-register busy scoreboard and optional write bypass.
// Latency: reads and busy flags 0 cycles (combinational); writes/reserves land at the edge; rsv_err 1 cycle.
// Backpressure: none; consumers stall on busy_a/busy_b, double reserves flagged on rsv_err.
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic            clk,
  input  logic            reset,
  reg_file_param_if.slave rf
);
  localparam int DEPTH = rf_depth(ADDR_W);
  localparam bit ZR    = (ZERO_REG != 0);
  localparam bit BP    = (BYPASS != 0);

  logic             w_wr_ok;
  logic             w_rsv_ok;
  logic             w_wr_hits_rsv;
  logic [DEPTH-1:0] w_load;
  logic [DEPTH-1:0] w_busy_nxt;
  logic [DEPTH-1:0] r_busy;
  logic             r_rsv_err;
  logic [WIDTH-1:0] w_q [DEPTH];
  logic             w_zero_a;
  logic             w_zero_b;
  logic             w_byp_a;
  logic             w_byp_b;

  // With a hard-wired zero register, writes and reserves to address 0 simply vanish.
  assign w_wr_ok       = rf.wr  && !(ZR && (rf.wr_addr  == '0));
  assign w_rsv_ok      = rf.rsv && !(ZR && (rf.rsv_addr == '0));
  assign w_wr_hits_rsv = w_wr_ok && (rf.wr_addr == rf.rsv_addr);

  // One-hot load strobe for the addressed storage register
  always_comb begin
    w_load = '0;
    if (w_wr_ok) begin
      w_load[rf.wr_addr] = 1'b1;
    end
  end

  // Storage array; register 0 is never loaded when ZERO_REG is set, so it stays 0.
  for (genvar g = 0; g < DEPTH; g++) begin : g_reg
    dfrl_n #(
      .WIDTH (WIDTH)
    ) u_reg (
      .i_clk (clk),
      .i_rst (reset),
      .i_ld  (w_load[g]),
      .i_d   (rf.d_in),
      .o_q   (w_q[g])
    );
  end

  // Next busy vector: the write retires its producer first, then a same-cycle
  // reserve re-marks the register for the newer producer.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_ok) begin
      w_busy_nxt[rf.wr_addr] = 1'b0;
    end
    if (w_rsv_ok) begin
      w_busy_nxt[rf.rsv_addr] = 1'b1;
    end
  end

  // Scoreboard state and the double-reserve pulse; reset drops every reservation.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy    <= '0;
      r_rsv_err <= 1'b0;
    end else begin
      r_busy    <= w_busy_nxt;
      r_rsv_err <= w_rsv_ok && r_busy[rf.rsv_addr] && !w_wr_hits_rsv;
    end
  end

  // Read port A: zero register, then same-cycle forward, then stored state
  always_comb begin
    w_zero_a = ZR && (rf.rd_addr_a == '0);
    w_byp_a  = BP && rf.wr && (rf.wr_addr == rf.rd_addr_a);
    if (w_zero_a) begin
      rf.d_out_a = '0;
      rf.busy_a  = 1'b0;
    end else if (w_byp_a) begin
      rf.d_out_a = rf.d_in;
      rf.busy_a  = 1'b0;
    end else begin
      rf.d_out_a = w_q[rf.rd_addr_a];
      rf.busy_a  = r_busy[rf.rd_addr_a];
    end
  end

  // Read port B: same selection as port A, fully independent of it
  always_comb begin
    w_zero_b = ZR && (rf.rd_addr_b == '0);
    w_byp_b  = BP && rf.wr && (rf.wr_addr == rf.rd_addr_b);
    if (w_zero_b) begin
      rf.d_out_b = '0;
      rf.busy_b  = 1'b0;
    end else if (w_byp_b) begin
      rf.d_out_b = rf.d_in;
      rf.busy_b  = 1'b0;
    end else begin
      rf.d_out_b = w_q[rf.rd_addr_b];
      rf.busy_b  = r_busy[rf.rd_addr_b];
    end
  end

  assign rf.rsv_err = r_rsv_err;
endmodule

// File: tb/tb_reg_file_param.sv
// Bench for two register file builds: 16x8 zero-reg-off/bypass-on and 32x32 zero-reg-on/bypass-off.
// Latency: expectations are pushed when stimulus is applied and popped on the following falling edge.
// Backpressure: none; every cycle produces one expectation per instance.
module tb_reg_file_param;
  import reg_file_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_file_param_if #(.WIDTH(16), .ADDR_W(3)) if0 ();
  reg_file_param_if #(.WIDTH(32), .ADDR_W(5)) if1 ();

  reg_file_param #(.WIDTH(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) dut0 (
    .clk(clk), .reset(reset), .rf(if0)
  );
  reg_file_param #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut1 (
    .clk(clk), .reset(reset), .rf(if1)
  );

  typedef struct {
    logic [31:0] da;
    logic [31:0] db;
    logic        ba;
    logic        bb;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state: instance 0 uses entries 0..7 and the low 16 data bits.
  logic [31:0] m_reg  [2][32];
  bit          m_busy [2][32];
  bit          m_err  [2];

  function automatic logic [4:0] amask(input int k, input logic [4:0] a);
    return (k == 1) ? a : (a & 5'h07);
  endfunction

  function automatic logic [31:0] dmask(input int k, input logic [31:0] d);
    return (k == 1) ? d : (d & 32'h0000_FFFF);
  endfunction

  // What a reader of address ra sees this cycle: {busy, data}
  function automatic logic [32:0] rd_one(input int k, input bit wr, input logic [4:0] wa,
                                         input logic [31:0] d, input logic [4:0] ra);
    bit zr = (k == 1);
    bit bp = (k == 0);
    if (zr && ra == 5'd0) return 33'h0;
    if (bp && wr && wa == ra) return {1'b0, dmask(k, d)};
    return {m_busy[k][ra], m_reg[k][ra]};
  endfunction

  // Architectural effect of one clock edge
  function automatic void upd(input int k, input bit rst, input bit wr, input logic [4:0] wa,
                              input logic [31:0] d, input bit rsv, input logic [4:0] ra);
    bit zr  = (k == 1);
    bit wok = wr  && !(zr && wa == 5'd0);
    bit rok = rsv && !(zr && ra == 5'd0);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[k][i]  = 32'h0;
        m_busy[k][i] = 1'b0;
      end
      m_err[k] = 1'b0;
      return;
    end
    m_err[k] = rok && m_busy[k][ra] && !(wok && wa == ra);
    if (wok) begin
      m_reg[k][wa]  = dmask(k, d);
      m_busy[k][wa] = 1'b0;
    end
    if (rok) m_busy[k][ra] = 1'b1;
  endfunction

  task automatic drive(input bit rst, input bit wr, input logic [4:0] wa, input logic [31:0] d,
                       input logic [4:0] ra, input logic [4:0] rb,
                       input bit rsv, input logic [4:0] rsa, input bit chk);
    exp_t e;
    logic [32:0] r;
    @(posedge clk);
    #1;
    reset         = rst;
    if0.wr        = wr;       if1.wr        = wr;
    if0.wr_addr   = wa[2:0];  if1.wr_addr   = wa;
    if0.d_in      = d[15:0];  if1.d_in      = d;
    if0.rd_addr_a = ra[2:0];  if1.rd_addr_a = ra;
    if0.rd_addr_b = rb[2:0];  if1.rd_addr_b = rb;
    if0.rsv       = rsv;      if1.rsv       = rsv;
    if0.rsv_addr  = rsa[2:0]; if1.rsv_addr  = rsa;
    for (int k = 0; k < 2; k++) begin
      if (chk) begin
        r     = rd_one(k, wr, amask(k, wa), d, amask(k, ra));
        e.da  = r[31:0];
        e.ba  = r[32];
        r     = rd_one(k, wr, amask(k, wa), d, amask(k, rb));
        e.db  = r[31:0];
        e.bb  = r[32];
        e.err = m_err[k];
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
      upd(k, rst, wr, amask(k, wa), d, rsv, amask(k, rsa));
    end
  endtask

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d t=%0t got=%h want=%h", name, k, $time, act, exp);
    end
  endtask

  // Monitor: the DUT presents read data every cycle; compare against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("d_out_a", 0, {16'h0, if0.d_out_a}, e.da);
      chk("d_out_b", 0, {16'h0, if0.d_out_b}, e.db);
      chk("busy_a",  0, {31'h0, if0.busy_a},  {31'h0, e.ba});
      chk("busy_b",  0, {31'h0, if0.busy_b},  {31'h0, e.bb});
      chk("rsv_err", 0, {31'h0, if0.rsv_err}, {31'h0, e.err});
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("d_out_a", 1, if1.d_out_a,          e.da);
      chk("d_out_b", 1, if1.d_out_b,          e.db);
      chk("busy_a",  1, {31'h0, if1.busy_a},  {31'h0, e.ba});
      chk("busy_b",  1, {31'h0, if1.busy_b},  {31'h0, e.bb});
      chk("rsv_err", 1, {31'h0, if1.rsv_err}, {31'h0, e.err});
    end
  end

  initial begin
    // Storage is unknown until the first reset edge, so that cycle is not checked.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
    // Every address reads zero and idle after reset
    for (int a = 0; a < 32; a++) drive(0, 0, 0, 0, 5'(a), 5'(31 - a), 0, 0, 1);
    // Write then read back; neighbours untouched
    drive(0, 1, 5, 32'h0000_1234, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 5, 4, 0, 0, 1);
    drive(0, 0, 0, 0, 6, 13, 0, 0, 1);
    // Same-cycle write forwarding (instance 0) versus none (instance 1)
    drive(0, 1, 3, 32'h0000_BEEF, 1, 3, 0, 0, 1);
    drive(0, 0, 0, 0, 3, 3, 0, 0, 1);
    // Reserve, double reserve, one-cycle error pulse, write retires the producer
    drive(0, 0, 0, 0, 2, 2, 1, 2, 1);
    drive(0, 0, 0, 0, 2, 7, 1, 2, 1);
    drive(0, 0, 0, 0, 2, 2, 0, 0, 1);
    drive(0, 0, 0, 0, 2, 2, 0, 0, 1);
    drive(0, 1, 2, 32'h0000_0042, 2, 2, 0, 0, 1);
    drive(0, 0, 0, 0, 2, 2, 0, 0, 1);
    // Write and reserve together, then a reset drops the reservation
    drive(0, 1, 6, 32'h0000_00AA, 6, 6, 1, 6, 1);
    drive(0, 0, 0, 0, 6, 6, 0, 0, 1);
    drive(0, 0, 0, 0, 6, 6, 0, 0, 1);
    drive(1, 0, 0, 0, 6, 6, 0, 0, 1);
    drive(0, 0, 0, 0, 6, 6, 0, 0, 1);
    // Address 0: ordinary register on instance 0, hard-wired zero on instance 1
    drive(0, 1, 0, 32'hFFFF_FFFF, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Busy release timing: write to a reserved register while reading it
    drive(0, 0, 0, 0, 4, 4, 1, 4, 1);
    drive(0, 1, 4, 32'h5A5A_A5A5, 4, 4, 0, 0, 1);
    drive(0, 0, 0, 0, 4, 4, 0, 0, 1);
    // High addresses only the wide instance can reach distinctly
    drive(0, 1, 29, 32'hCAFE_F00D, 29, 21, 1, 21, 1);
    drive(0, 0, 0, 0, 29, 21, 0, 0, 1);
    // Randomized traffic, addresses biased low to force collisions
    for (int n = 0; n < 600; n++) begin
      logic [4:0] wa, ra, rb, rsa;
      wa  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      rb  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      rsa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) rb = wa;
      drive(($urandom_range(0, 79) == 0), ($urandom_range(0, 1) == 1), wa, $urandom(),
            ra, rb, ($urandom_range(0, 2) == 0), rsa, 1);
    end
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d/%0d want=0/0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
